disp_mux8: RTL and testbench

- Downstream display stage of the calculator core. It consumes the serial digit stream (status, data, pos) and assembles it into an 8-digit shadow buffer.
- When a print burst completes, the shadow buffer is committed to a display buffer.
- The display buffer is time-multiplexed onto eight active-low common-anode 7-segment digits, with leading-zero blanking and an "Error" message.

---
 rtl/disp_pkg.sv | 48 ++++
 rtl/disp_mux8_bcd7seg.sv | 13 +
 rtl/disp_mux8.sv | 108 ++++++++++
 tb/tb_disp_mux8.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and segment lookups for the
// multiplexed 8-digit display stage.
package disp_pkg;

   localparam logic [1:0] ST_ERR   = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_READY = 2'b10;
   localparam logic [1:0] ST_PRINT = 2'b11;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_R     = 8'hAF;
   localparam logic [7:0] SEG_O     = 8'hA3;

   // active-low, dp off; anything past 9 is blank
   function automatic logic [7:0] digit_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // "Error" spelled right-aligned on digits 4..0
   function automatic logic [7:0] err_seg(input logic [2:0] k);
      logic [7:0] s;
      case (k)
         3'd4:    s = SEG_E;
         3'd3:    s = SEG_R;
         3'd2:    s = SEG_R;
         3'd1:    s = SEG_O;
         3'd0:    s = SEG_R;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/disp_mux8_bcd7seg.sv
// BCD to active-low 7-segment decoder, dp off.
// Codes above 9 decode as blank.
module bcd7seg (
   input  logic [3:0] digit,
   output logic [7:0] seg
);
   import disp_pkg::*;

   always_comb begin
      seg = digit_seg(digit);
   end

endmodule

// File: rtl/disp_mux8.sv
// Display stage: captures the serial digit stream, commits
// at end of burst and scans eight common-anode digits.
module disp_mux8 #(
   parameter int REFRESH_DIV = 50000,
   parameter int NDIG        = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] status,
   input  logic [3:0] data,
   input  logic [3:0] pos,
   output logic [7:0] an,
   output logic [7:0] seg,
   output logic       busy_led
);
   import disp_pkg::*;

   localparam int CW = $clog2(REFRESH_DIV);

   logic [NDIG-1:0][3:0] shadow;
   logic [NDIG-1:0][3:0] disp;
   logic [1:0]           prev_status;
   logic                 err_latched;

   logic [CW-1:0]        rcnt;
   logic [2:0]           idx;

   logic                 cap_en;
   logic                 commit_en;
   logic [2:0]           wr_idx;
   logic [2:0]           msd;
   logic [3:0]           cur;
   logic [7:0]           dec_seg;
   logic [7:0]           nxt_seg;

   assign cap_en    = !err_latched
                    && status == ST_PRINT
                    && pos != 4'd0
                    && pos <= 4'd8;
   assign commit_en = !err_latched
                    && prev_status == ST_PRINT
                    && status == ST_READY;
   assign wr_idx    = 3'(pos - 4'd1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow      <= '0;
         disp        <= '0;
         prev_status <= ST_READY;
         err_latched <= 1'b0;
         busy_led    <= 1'b0;
      end else begin
         prev_status <= status;
         busy_led    <= (status == ST_BUSY);
         if (status == ST_ERR)
            err_latched <= 1'b1;
         // commit samples the shadow as it was before this edge
         if (commit_en)
            disp <= shadow;
         if (cap_en)
            shadow[wr_idx] <= data;
      end
   end

   always_comb begin
      msd = '0;
      for (int k = 0; k < NDIG; k++) begin
         if (disp[k] != 4'd0)
            msd = 3'(k);
      end
   end

   assign cur = disp[idx];

   bcd7seg u_dec (
      .digit (cur),
      .seg   (dec_seg)
   );

   always_comb begin
      if (err_latched)
         nxt_seg = err_seg(idx);
      else if (idx > msd)
         nxt_seg = SEG_BLANK;
      else
         nxt_seg = dec_seg;
   end

   // an and seg load together so a digit never shows a stale pattern
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rcnt <= '0;
         idx  <= '0;
         an   <= 8'hFF;
         seg  <= SEG_BLANK;
      end else begin
         an  <= ~(8'd1 << idx);
         seg <= nxt_seg;
         if (rcnt == CW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= idx + 3'd1;
         end else begin
            rcnt <= rcnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_disp_mux8.sv
// Bench for disp_mux8: cycle-level reference model plus
// literal spot checks of the rendered digits.
module tb_disp_mux8;

   localparam int DIV = 4;

   logic       clock  = 1'b0;
   logic       reset  = 1'b1;
   logic [1:0] status = 2'b10;
   logic [3:0] data   = 4'd0;
   logic [3:0] pos    = 4'd0;
   logic [7:0] an;
   logic [7:0] seg;
   logic       busy_led;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   disp_mux8 #(.REFRESH_DIV(DIV), .NDIG(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .status   (status),
      .data     (data),
      .pos      (pos),
      .an       (an),
      .seg      (seg),
      .busy_led (busy_led)
   );

   always #5 clock = ~clock;

   // reference model state
   int   m_disp[8];
   int   m_shadow[8];
   int   m_prev;
   int   m_n;
   bit   m_err;
   logic [7:0] seen[8];

   function automatic logic [7:0] dig_seg(int v);
      case (v)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] err_txt(int k);
      case (k)
         4: return 8'h86;
         3: return 8'hAF;
         2: return 8'hAF;
         1: return 8'hA3;
         0: return 8'hAF;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] model_seg(int k);
      int msd;
      msd = 0;
      if (m_err) return err_txt(k);
      for (int i = 0; i < 8; i++)
         if (m_disp[i] != 0) msd = i;
      if (k > msd) return 8'hFF;
      return dig_seg(m_disp[k]);
   endfunction

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_disp[i]   = 0;
         m_shadow[i] = 0;
      end
      m_prev = 2;
      m_n    = 0;
      m_err  = 0;
   endtask

   always @(posedge clock) begin
      logic [7:0] ea;
      logic [7:0] es;
      logic       eb;
      int         k;
      if (reset) begin
         model_reset();
         ea = 8'hFF;
         es = 8'hFF;
         eb = 1'b0;
      end else begin
         k  = (m_n / DIV) % 8;
         ea = ~(8'd1 << k);
         es = model_seg(k);
         eb = (status == 2'b01);
         if (!m_err) begin
            if (m_prev == 3 && status == 2'b10)
               m_disp = m_shadow;
            if (status == 2'b11 && pos >= 1 && pos <= 8)
               m_shadow[pos - 1] = int'(data);
         end
         if (status == 2'b00) m_err = 1;
         m_prev = int'(status);
         m_n++;
      end
      #1;
      chk("an", an, ea);
      chk("seg", seg, es);
      chk("busy_led", {7'd0, busy_led}, {7'd0, eb});
      for (int i = 0; i < 8; i++)
         if (an == ~(8'd1 << i)) seen[i] = seg;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_seen();
      for (int i = 0; i < 8; i++) seen[i] = 8'h00;
   endtask

   // exp packs digit7..digit0, one byte each
   task automatic chk_seen(input string nm, input logic [63:0] exp);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_d%0d", nm, i), seen[i], exp[i*8 +: 8]);
   endtask

   // digits packs digit p-1 at nibble p-1
   task automatic burst(input logic [31:0] digits);
      status = 2'b11;
      pos    = 4'd0;
      data   = 4'd0;
      @(negedge clock);
      for (int p = 1; p <= 8; p++) begin
         pos  = 4'(p);
         data = digits[4*(p-1) +: 4];
         @(negedge clock);
      end
      status = 2'b10;
      pos    = 4'd0;
      @(negedge clock);
   endtask

   task automatic show(input string nm, input logic [63:0] exp);
      idle(8);
      clear_seen();
      idle(34);
      chk_seen(nm, exp);
   endtask

   initial begin
      model_reset();
      clear_seen();
      repeat (3) @(negedge clock);
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_busy", {7'd0, busy_led}, 8'h00);
      reset = 1'b0;

      clear_seen();
      idle(34);
      chk_seen("idle", 64'hFFFF_FFFF_FFFF_FFC0);

      burst(32'h0000_0123);
      show("n123", 64'hFFFF_FFFF_FFF9_A4B0);

      status = 2'b01;
      @(posedge clock);
      #2;
      chk("busy_on", {7'd0, busy_led}, 8'h01);
      idle(10);
      status = 2'b10;
      @(posedge clock);
      #2;
      chk("busy_off", {7'd0, busy_led}, 8'h00);
      show("n123_kept", 64'hFFFF_FFFF_FFF9_A4B0);

      burst(32'h0000_0000);
      show("zero", 64'hFFFF_FFFF_FFFF_FFC0);

      for (int r = 0; r < 8; r++) begin
         status = 2'b11;
         for (int p = 0; p < 12; p++) begin
            pos  = 4'($urandom_range(0, 15));
            data = 4'($urandom_range(0, 15));
            @(negedge clock);
         end
         burst($urandom);
         if ($urandom_range(0, 1) == 1) begin
            status = 2'b01;
            idle($urandom_range(1, 6));
         end
         status = 2'b10;
         idle($urandom_range(10, 40));
      end

      status = 2'b00;
      @(negedge clock);
      status = 2'b10;
      burst(32'h5555_5555);
      show("err", 64'hFFFF_FF86_AFAF_A3AF);

      status = 2'b11;
      for (int p = 1; p <= 4; p++) begin
         pos  = 4'(p);
         data = 4'(p + 4);
         @(negedge clock);
      end
      #2;
      reset = 1'b1;
      #1;
      chk("async_an", an, 8'hFF);
      chk("async_seg", seg, 8'hFF);
      status = 2'b10;
      pos    = 4'd0;
      idle(2);
      reset = 1'b0;
      clear_seen();
      idle(34);
      chk_seen("post_rst", 64'hFFFF_FFFF_FFFF_FFC0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
